// File: rtl/ft2232h_tx_writer_if.sv
// User byte stream and FT2232H sync-FIFO write bus for ft2232h_tx_writer.
// master drives the user/chip inputs, slave is the writer block.
interface ft2232h_tx_writer_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    data_i;
  logic          valid_i;
  logic          ready_o;
  logic          txe_i;
  logic          wr_o;
  logic [7:0]    data_o;
  logic          data_oe_o;
  logic [CW-1:0] count_o;

  modport master (
    output data_i, valid_i, txe_i,
    input  ready_o, wr_o, data_o,
    input  data_oe_o, count_o
  );

  modport slave (
    input  data_i, valid_i, txe_i,
    output ready_o, wr_o, data_o,
    output data_oe_o, count_o
  );
endinterface

// File: rtl/ft2232h_tx_writer.sv
// Buffers user bytes and writes them to an FT2232H sync FIFO.
// FT2232H_TX_PREAMBLE_EN: prefix each FRAME_LEN-byte frame with PREAMBLE.
module ft2232h_tx_writer #(
  parameter int         DEPTH     = 16,
  parameter int         FRAME_LEN = 8,
  parameter logic [7:0] PREAMBLE  = 8'hAA
) (
  input  logic clk_i,
  input  logic rst_i,
  ft2232h_tx_writer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

`ifdef FT2232H_TX_PREAMBLE_EN
  typedef enum logic [1:0] {IDLE, PRE, SEND} st_t;
`else
  typedef enum logic [1:0] {IDLE, SEND} st_t;
`endif

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  st_t           state_q, state_d;
  logic          wr_q, wr_d;
  logic          oe_q, oe_d;
  logic [7:0]    dat_q, dat_d;
`ifdef FT2232H_TX_PREAMBLE_EN
  logic [7:0]    frm_q, frm_d;
`else
  logic          unused_cfg;
  assign unused_cfg = ^{PREAMBLE, 8'(FRAME_LEN)};
`endif

  logic       push, pop, xfer;
  logic [7:0] head, next_head;

  assign bus.ready_o   = (cnt_q < CW'(DEPTH));
  assign bus.wr_o      = wr_q;
  assign bus.data_o    = dat_q;
  assign bus.data_oe_o = oe_q;
  assign bus.count_o   = cnt_q;

  assign push      = bus.valid_i && bus.ready_o;
  assign xfer      = !wr_q && !bus.txe_i;
  assign head      = mem_q[rd_ptr_q];
  assign next_head = mem_q[rd_ptr_q + AW'(1)];

  // Bus FSM: a byte leaves on every edge with WR# and TXE# both low.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    oe_d    = oe_q;
    dat_d   = dat_q;
    pop     = 1'b0;
`ifdef FT2232H_TX_PREAMBLE_EN
    frm_d   = frm_q;
`endif
    unique case (state_q)
      IDLE: begin
        wr_d = 1'b1;
        oe_d = 1'b0;
        if (cnt_q != '0 && !bus.txe_i) begin
          wr_d = 1'b0;
          oe_d = 1'b1;
`ifdef FT2232H_TX_PREAMBLE_EN
          state_d = PRE;
          dat_d   = PREAMBLE;
`else
          state_d = SEND;
          dat_d   = head;
`endif
        end
      end
`ifdef FT2232H_TX_PREAMBLE_EN
      PRE: begin
        if (xfer) begin
          state_d = SEND;
          dat_d   = head;
        end
      end
`endif
      SEND: begin
        if (wr_q) begin
          if (cnt_q != '0) begin
            wr_d  = 1'b0;
            dat_d = head;
          end
        end else if (xfer) begin
          pop = 1'b1;
`ifdef FT2232H_TX_PREAMBLE_EN
          frm_d = frm_q + 8'd1;
          if (frm_q + 8'd1 == 8'(FRAME_LEN)) begin
            frm_d   = 8'd0;
            state_d = IDLE;
            wr_d    = 1'b1;
            oe_d    = 1'b0;
          end else if (cnt_q > CW'(1)) begin
            dat_d = next_head;
          end else begin
            wr_d = 1'b1;
          end
`else
          if (cnt_q > CW'(1)) begin
            dat_d = next_head;
          end else begin
            state_d = IDLE;
            wr_d    = 1'b1;
            oe_d    = 1'b0;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointer and occupancy next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
  end

  // Byte storage; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= bus.data_i;
  end

  // State, bus and pointer registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      wr_q     <= 1'b1;
      oe_q     <= 1'b0;
      dat_q    <= 8'h00;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
`ifdef FT2232H_TX_PREAMBLE_EN
      frm_q    <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      oe_q     <= oe_d;
      dat_q    <= dat_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
`ifdef FT2232H_TX_PREAMBLE_EN
      frm_q    <= frm_d;
`endif
    end
  end
endmodule

// File: tb/tb_ft2232h_tx_writer.sv
// Scoreboard bench for ft2232h_tx_writer.
// Expected bus bytes are queued on push and checked per transfer.
module tb_ft2232h_tx_writer;
  localparam int DEPTH = 16;
  localparam int FL    = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ft2232h_tx_writer_if #(.DEPTH(DEPTH)) bus ();

  ft2232h_tx_writer #(
    .DEPTH(DEPTH),
    .FRAME_LEN(FL),
    .PREAMBLE(8'hAA)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int xfers   = 0;
  logic [7:0] exp_q [$];
`ifdef FT2232H_TX_PREAMBLE_EN
  int k = 0;
`endif

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_push(input logic [7:0] b);
`ifdef FT2232H_TX_PREAMBLE_EN
    if (k == 0) exp_q.push_back(8'hAA);
    k = (k + 1) % FL;
`endif
    exp_q.push_back(b);
  endfunction

  // Monitor: WR# and TXE# low at negedge means a transfer at next posedge.
  always @(negedge clk) begin
    if (rst_n && bus.wr_o === 1'b0 && bus.txe_i === 1'b0) begin
      xfers++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_xfer: got %0h expected none", bus.data_o);
      end else begin
        chk("xfer_data", {24'd0, bus.data_o}, {24'd0, exp_q.pop_front()});
        chk("xfer_oe", {31'd0, bus.data_oe_o}, 32'd1);
      end
    end
  end

  // Called at #1 after a posedge; returns there one cycle later.
  task automatic push(input logic [7:0] b, output bit acc);
    bus.valid_i = 1'b1;
    bus.data_i  = b;
    @(negedge clk);
    acc = bus.ready_o;
    if (acc) model_push(b);
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    chk({name, "_drained"}, exp_q.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk({name, "_wr_idle"}, {31'd0, bus.wr_o}, 32'd1);
    chk({name, "_count0"}, {27'd0, bus.count_o}, 32'd0);
  endtask

  bit acc;
  int acc_n;
  int start;
  logic [7:0] d0;

  initial begin
    bus.valid_i = 1'b0;
    bus.data_i  = 8'h00;
    bus.txe_i   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr", {31'd0, bus.wr_o}, 32'd1);
    chk("rst_oe", {31'd0, bus.data_oe_o}, 32'd0);
    chk("rst_data", {24'd0, bus.data_o}, 32'd0);
    chk("rst_count", {27'd0, bus.count_o}, 32'd0);
    chk("rst_ready", {31'd0, bus.ready_o}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two bytes; WR# must not drop on the push edge itself.
    bus.txe_i = 1'b0;
    push(8'h10, acc);
    chk("no_early_wr", {31'd0, bus.wr_o}, 32'd1);
    push(8'h11, acc);
    wait_drain("two_bytes");

    // One frame worth of bytes back-to-back.
    for (int i = 1; i <= 8; i++) push(8'(i), acc);
    wait_drain("frame");

    // TXE# stall with WR# low: data must hold.
    bus.txe_i = 1'b1;
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i), acc);
    for (int i = 0; i < 8; i++) begin
      if (bus.wr_o == 1'b0) break;
      bus.txe_i = 1'b0;
      @(posedge clk);
      #1;
      bus.txe_i = 1'b1;
    end
    chk("stall_wr_low", {31'd0, bus.wr_o}, 32'd0);
    d0 = bus.data_o;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_wr_hold", {31'd0, bus.wr_o}, 32'd0);
      chk("stall_data_hold", {24'd0, bus.data_o}, {24'd0, d0});
    end
    @(posedge clk);
    #1;
    bus.txe_i = 1'b0;
    wait_drain("stall");

    // Overfill while the chip is full.
    bus.txe_i = 1'b1;
    acc_n = 0;
    for (int i = 0; i < 20; i++) begin
      push(8'h40 + 8'(i), acc);
      acc_n += int'(acc);
    end
    chk("full_accepted", acc_n, 32'd16);
    chk("full_count", {27'd0, bus.count_o}, 32'd16);
    chk("full_ready", {31'd0, bus.ready_o}, 32'd0);
    bus.txe_i = 1'b0;
    wait_drain("full");

    // Input gap mid-frame.
    for (int i = 0; i < 3; i++) push(8'h50 + 8'(i), acc);
    repeat (6) @(posedge clk);
    #1;
    chk("gap_wr_high", {31'd0, bus.wr_o}, 32'd1);
    for (int i = 3; i < 8; i++) push(8'h50 + 8'(i), acc);
    wait_drain("gap");

    // Reset after four bus transfers.
    bus.txe_i = 1'b1;
    for (int i = 0; i < 8; i++) push(8'h60 + 8'(i), acc);
    start = xfers;
    bus.txe_i = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (xfers - start >= 4) break;
    end
    chk("rst_mid_reached", xfers - start, 32'd4);
    rst_n = 1'b0;
    bus.txe_i = 1'b1;
    exp_q.delete();
`ifdef FT2232H_TX_PREAMBLE_EN
    k = 0;
`endif
    @(posedge clk);
    #1;
    chk("rst_mid_wr", {31'd0, bus.wr_o}, 32'd1);
    chk("rst_mid_count", {27'd0, bus.count_o}, 32'd0);
    chk("rst_mid_oe", {31'd0, bus.data_oe_o}, 32'd0);
    rst_n = 1'b1;
    chk("rst_mid_ready", {31'd0, bus.ready_o}, 32'd1);
    bus.txe_i = 1'b0;
    push(8'h70, acc);
    push(8'h71, acc);
    wait_drain("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ft2232h_tx_writer.md
FT2232H_TX_WRITER -- requirements
Module: ft2232h_tx_writer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, giving the internal byte FIFO depth (power of two, at least 4).
REQ-002 The block SHALL have parameter FRAME_LEN, default 8, giving the number of user bytes per frame (1..255).
REQ-003 The block SHALL have parameter PREAMBLE, default 8'hAA, giving the frame preamble byte.
REQ-004 clk_i  input  1  single clock: the FT2232H 60 MHz CLKOUT; all logic on its rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-low.
REQ-006 data_i  input  8  user byte to send to the PC.
REQ-007 valid_i  input  1  data_i is valid this cycle.
REQ-008 ready_o  output  1  block accepts data_i this cycle.
REQ-009 txe_i  input  1  FT2232H TXE#, active-low; low means the chip FIFO has space.
REQ-010 wr_o  output  1  FT2232H WR#, active-low, registered.
REQ-011 data_o  output  8  byte driven onto the FT2232H data bus, registered.
REQ-012 data_oe_o  output  1  drive enable for the bidirectional data bus, registered.
REQ-013 count_o  output  log2(DEPTH)+1  current internal FIFO occupancy.

Function
REQ-014 A user byte SHALL be pushed on each rising edge where valid_i=1 and ready_o=1.
REQ-015 ready_o SHALL equal 1 exactly when count_o<DEPTH; ready_o SHALL be combinational from the occupancy register only.
REQ-016 A byte SHALL count as transferred to the FT2232H on a rising edge where wr_o=0 and txe_i=0, both sampled at that edge.
REQ-017 If txe_i=1 at an edge where wr_o=0, no transfer SHALL occur, and data_o SHALL hold its value until that byte transfers.
REQ-018 The FSM SHALL have states IDLE, PRE and SEND.
REQ-019 In IDLE (wr_o=1, data_oe_o=0), if count_o>0 and txe_i=0, the FSM SHALL move to PRE when the preamble is enabled (REQ-030), otherwise to SEND; in both cases data_oe_o SHALL go to 1.
REQ-020 In PRE, data_o SHALL be PREAMBLE with wr_o=0; on transfer of the preamble the FSM SHALL go to SEND.
REQ-021 In SEND, data_o SHALL be the FIFO head byte with wr_o=0; each transfer SHALL pop the head and increment an 8-bit frame counter.
REQ-022 When the frame counter reaches FRAME_LEN, the counter SHALL clear to 0 and the FSM SHALL return to IDLE.
REQ-023 Mid-frame FIFO empty: wr_o SHALL go to 1, the FSM SHALL stay in SEND, and the frame counter SHALL be retained; writing SHALL resume when a byte arrives, with no new preamble.
REQ-024 A push and a pop in the same cycle SHALL leave count_o unchanged, and the head byte SHALL be ordered correctly.
REQ-025 A push to an empty FIFO SHALL become writable to the FT2232H no earlier than the next cycle (minimum 2 cycles from push to WR# low).
REQ-026 FIFO read and write pointers SHALL wrap modulo DEPTH; count_o SHALL never exceed DEPTH or underflow.
REQ-027 Sustained throughput SHALL be one byte per clock while txe_i=0 and the FIFO is non-empty.

Reset
REQ-028 When rst_i=0 at a rising edge, the block SHALL set: FSM to IDLE, wr_o=1, data_oe_o=0, data_o=8'h00, pointers=0, count_o=0, frame counter=0.
REQ-029 A reset mid-frame SHALL discard all buffered bytes and start the next frame with a preamble (when enabled); ready_o SHALL be 1 in the first cycle after reset.

Configuration
REQ-030 With macro FT2232H_TX_PREAMBLE_EN defined, the block SHALL write the PREAMBLE byte ahead of every FRAME_LEN user bytes and implement the PRE state.
REQ-031 Without FT2232H_TX_PREAMBLE_EN, the PRE state SHALL be absent, IDLE SHALL go directly to SEND, and the output SHALL be a raw byte stream with the frame counter unused.

Verification
REQ-032 Scenario (macro on): push 8'h01..8'h08 with txe_i=0 -> bus transfers AA,01,02,...,08 on 9 consecutive edges, then wr_o=1.
REQ-033 Scenario: hold txe_i=1 for 3 cycles after the preamble is presented -> data_o stays at AA with wr_o=0, and no duplicate or lost byte.
REQ-034 Scenario: push 20 bytes back-to-back while txe_i=1 -> ready_o drops after 16 bytes, count_o=16, and all 16 bytes are later emitted in order.
REQ-035 Scenario: push 3 bytes, stall input, then push 5 bytes -> a single preamble, 8 data bytes in order, wr_o=1 during the gap.
REQ-036 Scenario: drive rst_i=0 after 4 bytes of a frame -> wr_o=1 and count_o=0 on the next edge, and the next frame begins with AA.
REQ-037 Scenario (macro off): push 8'h10, 8'h11 -> bus transfers 10, 11 only.
